// File: rtl/fir_stream_ctrl.sv
// Configuration validator and stream sequencer in front of the FIR/FIFO datapath: IDLE -> LOAD -> STREAM, with FLUSH on reconfig.
// Samples reach the FIFO put port one cycle after handshake; src_ready follows full combinationally (no skid buffer).
module fir_stream_ctrl #(
    parameter int FS_HALF      = 22050,
    parameter int FLUSH_CYCLES = 64,
    parameter int LOAD_TIMEOUT = 4096,
    parameter int DW           = 32
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [15:0]   cfg_bandlow,
    input  logic [15:0]   cfg_bandhi,
    input  logic [1:0]    cfg_select,
    output logic          cfg_err,
    input  logic          coe_done,
    output logic          start_coe,
    output logic [15:0]   bandlow,
    output logic [15:0]   bandhi,
    output logic [1:0]    filter_select,
    input  logic          src_valid,
    input  logic [DW-1:0] src_data,
    output logic          src_ready,
    input  logic          full,
    output logic [DW-1:0] data_put,
    output logic          req_put,
    output logic          busy,
    output logic [31:0]   sample_cnt
);
    localparam int FW = $clog2(FLUSH_CYCLES + 1);
    localparam int LW = $clog2(LOAD_TIMEOUT);
    localparam logic [15:0]   FS_LIM     = 16'(FS_HALF);
    localparam logic [FW-1:0] FLUSH_INIT = FW'(FLUSH_CYCLES);
    localparam logic [LW-1:0] LOAD_LAST  = LW'(LOAD_TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM, S_FLUSH} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [FW-1:0]   r_flush_cnt;
    logic [LW-1:0]   r_load_cnt;
    logic [15:0]     r_bandlow, r_bandhi, r_pend_low, r_pend_hi;
    logic [1:0]      r_select, r_pend_sel;
    logic            r_cfg_err, r_req_put;
    logic [DW-1:0]   r_data_put;
    logic [31:0]     r_sample_cnt;

    logic w_cfg_ok, w_cfg_hs, w_src_hs, w_timeout, w_flush_done;
    logic w_apply_cfg, w_pend_ld;

    // Lowpass has no lower edge; highpass's implicit upper edge is Nyquist.
    always_comb begin
        w_cfg_ok = 1'b0;
        case (cfg_select)
            2'b00:   w_cfg_ok = (cfg_bandlow < cfg_bandhi) && (cfg_bandhi <= FS_LIM);
            2'b01:   w_cfg_ok = (cfg_bandhi <= FS_LIM);
            2'b10:   w_cfg_ok = (cfg_bandhi <= FS_LIM) && (cfg_bandlow < FS_LIM);
            default: w_cfg_ok = 1'b0;
        endcase
    end

    assign cfg_ready    = (r_state == S_IDLE) || (r_state == S_STREAM);
    assign w_cfg_hs     = cfg_valid && cfg_ready;
    assign src_ready    = (r_state == S_STREAM) && !full && !(cfg_valid && w_cfg_ok);
    assign w_src_hs     = src_valid && src_ready;
    assign w_timeout    = (r_state == S_LOAD) && !coe_done && (r_load_cnt == LOAD_LAST);
    assign w_flush_done = (r_state == S_FLUSH) && (r_flush_cnt <= FW'(1));
    assign w_apply_cfg  = w_cfg_hs && w_cfg_ok && (r_state == S_IDLE);
    assign w_pend_ld    = w_cfg_hs && w_cfg_ok && (r_state == S_STREAM);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_apply_cfg) w_state_nxt = S_LOAD;
            S_LOAD:   if (coe_done) w_state_nxt = S_STREAM;
                      else if (w_timeout) w_state_nxt = S_IDLE;
            S_STREAM: if (w_pend_ld) w_state_nxt = S_FLUSH;
            S_FLUSH:  if (w_flush_done) w_state_nxt = S_LOAD;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_flush_cnt  <= '0;
            r_load_cnt   <= '0;
            r_bandlow    <= '0;
            r_bandhi     <= '0;
            r_select     <= '0;
            r_pend_low   <= '0;
            r_pend_hi    <= '0;
            r_pend_sel   <= '0;
            r_cfg_err    <= 1'b0;
            r_req_put    <= 1'b0;
            r_data_put   <= '0;
            r_sample_cnt <= '0;
        end else begin
            r_cfg_err  <= (w_cfg_hs && !w_cfg_ok) || w_timeout;
            r_req_put  <= w_src_hs;
            r_load_cnt <= (r_state == S_LOAD) ? r_load_cnt + LW'(1) : '0;

            if (w_src_hs) begin
                r_data_put   <= src_data;
                r_sample_cnt <= r_sample_cnt + 32'd1;
            end else if ((r_state == S_LOAD) && coe_done) begin
                r_sample_cnt <= '0;
            end

            if (w_apply_cfg) begin
                r_bandlow <= cfg_bandlow;
                r_bandhi  <= cfg_bandhi;
                r_select  <= cfg_select;
            end else if (w_flush_done) begin
                r_bandlow <= r_pend_low;
                r_bandhi  <= r_pend_hi;
                r_select  <= r_pend_sel;
            end

            if (w_pend_ld) begin
                r_pend_low  <= cfg_bandlow;
                r_pend_hi   <= cfg_bandhi;
                r_pend_sel  <= cfg_select;
                r_flush_cnt <= FLUSH_INIT;
            end else if (r_state == S_FLUSH) begin
                r_flush_cnt <= r_flush_cnt - FW'(1);
            end
        end
    end

    // start_coe/busy decode from state so an async reset drops them immediately.
    assign start_coe     = (r_state == S_LOAD);
    assign busy          = (r_state == S_LOAD) || (r_state == S_FLUSH);
    assign cfg_err       = r_cfg_err;
    assign bandlow       = r_bandlow;
    assign bandhi        = r_bandhi;
    assign filter_select = r_select;
    assign data_put      = r_data_put;
    assign req_put       = r_req_put;
    assign sample_cnt    = r_sample_cnt;
endmodule

// File: tb/tb_fir_stream_ctrl.sv
// Directed bench for fir_stream_ctrl: config validity table plus load, stream, flush, timeout and async-reset sequences.
module tb_fir_stream_ctrl;
    logic        CLK, reset;
    logic        cfg_valid, cfg_ready;
    logic [15:0] cfg_bandlow, cfg_bandhi;
    logic [1:0]  cfg_select;
    logic        cfg_err, coe_done, start_coe;
    logic [15:0] bandlow, bandhi;
    logic [1:0]  filter_select;
    logic        src_valid, src_ready, full, req_put, busy;
    logic [31:0] src_data, data_put, sample_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    fir_stream_ctrl dut (
        .CLK(CLK), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_bandlow(cfg_bandlow), .cfg_bandhi(cfg_bandhi), .cfg_select(cfg_select),
        .cfg_err(cfg_err), .coe_done(coe_done), .start_coe(start_coe),
        .bandlow(bandlow), .bandhi(bandhi), .filter_select(filter_select),
        .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
        .full(full), .data_put(data_put), .req_put(req_put),
        .busy(busy), .sample_cnt(sample_cnt)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] lo;
        logic [15:0] hi;
        logic [1:0]  sel;
        logic        ok;
    } vec_t;
    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic set_cfg(input logic v, input logic [15:0] lo, input logic [15:0] hi, input logic [1:0] sel);
        cfg_valid = v; cfg_bandlow = lo; cfg_bandhi = hi; cfg_select = sel;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " start_coe"}, start_coe, 0);
        chk({tag, " req_put"}, req_put, 0);
        chk({tag, " data_put"}, data_put, 0);
        chk({tag, " bandlow"}, bandlow, 0);
        chk({tag, " bandhi"}, bandhi, 0);
        chk({tag, " filter_select"}, filter_select, 0);
        chk({tag, " cfg_err"}, cfg_err, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " sample_cnt"}, sample_cnt, 0);
    endtask

    initial begin
        int cnt, good, nxt;
        logic hs;

        reset = 1'b0; coe_done = 1'b0; src_valid = 1'b0; src_data = '0; full = 1'b0;
        set_cfg(1'b0, 16'd0, 16'd0, 2'b00);

        vecs[0] = '{16'd500,   16'd7000,  2'b00, 1'b1};
        vecs[1] = '{16'd7000,  16'd500,   2'b00, 1'b0};
        vecs[2] = '{16'd7000,  16'd7000,  2'b00, 1'b0};
        vecs[3] = '{16'd0,     16'd22050, 2'b00, 1'b1};
        vecs[4] = '{16'd0,     16'd22051, 2'b00, 1'b0};
        vecs[5] = '{16'd30000, 16'd1000,  2'b01, 1'b1};
        vecs[6] = '{16'd0,     16'd30000, 2'b01, 1'b0};
        vecs[7] = '{16'd20000, 16'd1000,  2'b10, 1'b1};
        vecs[8] = '{16'd100,   16'd23000, 2'b10, 1'b0};
        vecs[9] = '{16'd100,   16'd200,   2'b11, 1'b0};

        #1 reset = 1'b1;
        #2;
        chk_all_zero("reset");
        chk("reset cfg_ready", cfg_ready, 1);
        tick();
        reset = 1'b0;
        tick();

        // Config validity table, each applied from a fresh IDLE.
        for (int i = 0; i < 10; i++) begin
            do_reset();
            set_cfg(1'b1, vecs[i].lo, vecs[i].hi, vecs[i].sel);
            #1;
            chk("tbl cfg_ready", cfg_ready, 1);
            tick();
            set_cfg(1'b0, 16'd0, 16'd0, 2'b00);
            chk($sformatf("tbl%0d cfg_err", i), cfg_err, !vecs[i].ok);
            chk($sformatf("tbl%0d busy", i), busy, vecs[i].ok);
            chk($sformatf("tbl%0d bandlow", i), bandlow, vecs[i].ok ? vecs[i].lo : 16'd0);
            chk($sformatf("tbl%0d bandhi", i), bandhi, vecs[i].ok ? vecs[i].hi : 16'd0);
        end

        // Load: coe_done 10 cycles into LOAD.
        do_reset();
        set_cfg(1'b1, 16'd500, 16'd7000, 2'b00);
        tick();
        set_cfg(1'b0, 16'd0, 16'd0, 2'b00);
        chk("load bandlow", bandlow, 500);
        chk("load bandhi", bandhi, 7000);
        chk("load select", filter_select, 0);
        chk("load cfg_ready", cfg_ready, 0);
        cnt = 0;
        for (int i = 0; i <= 10; i++) begin
            if (start_coe) cnt++;
            if (i == 10) coe_done = 1'b1;
            tick();
        end
        coe_done = 1'b0;
        chk("load start_coe cycles", cnt, 11);
        chk("load start_coe low", start_coe, 0);
        chk("stream busy", busy, 0);
        chk("stream cfg_ready", cfg_ready, 1);
        chk("stream sample_cnt", sample_cnt, 0);

        // 100 samples with full held for 5 cycles mid-stream.
        nxt = 0;
        for (int c = 0; c < 110; c++) begin
            src_valid = (nxt < 100);
            src_data  = nxt;
            full      = (c >= 40 && c < 45);
            #1;
            chk("strm src_ready", src_ready, !full);
            hs = src_valid && !full;
            tick();
            chk("strm req_put", req_put, hs);
            if (hs) begin
                chk("strm data_put", data_put, nxt);
                nxt++;
            end
        end
        src_valid = 1'b0; full = 1'b0;
        chk("strm sample_cnt", sample_cnt, 100);
        chk("strm data hold", data_put, 99);

        // Invalid configs do not disturb streaming.
        set_cfg(1'b1, 16'd7000, 16'd500, 2'b00);
        src_valid = 1'b1; src_data = 32'd1000;
        #1;
        chk("inv1 src_ready", src_ready, 1);
        tick();
        chk("inv1 cfg_err", cfg_err, 1);
        chk("inv1 req_put", req_put, 1);
        chk("inv1 data_put", data_put, 1000);
        set_cfg(1'b1, 16'd0, 16'd30000, 2'b01);
        src_data = 32'd1001;
        tick();
        chk("inv2 cfg_err", cfg_err, 1);
        chk("inv2 data_put", data_put, 1001);
        set_cfg(1'b0, 16'd0, 16'd0, 2'b00);
        src_valid = 1'b0;
        tick();
        chk("inv cfg_err drop", cfg_err, 0);
        chk("inv bandlow", bandlow, 500);
        chk("inv bandhi", bandhi, 7000);
        chk("inv select", filter_select, 0);
        chk("inv busy", busy, 0);
        chk("inv sample_cnt", sample_cnt, 102);

        // Valid reconfig wins over a same-cycle sample, then flush and reload.
        set_cfg(1'b1, 16'd1000, 16'd4000, 2'b10);
        src_valid = 1'b1; src_data = 32'd2000;
        #1;
        chk("rcfg src_ready", src_ready, 0);
        tick();
        set_cfg(1'b0, 16'd0, 16'd0, 2'b00);
        chk("flush bandlow old", bandlow, 500);
        good = 0;
        for (int i = 0; i < 64; i++) begin
            if (!req_put && !start_coe && !src_ready && busy) good++;
            tick();
        end
        src_valid = 1'b0;
        chk("flush quiet cycles", good, 64);
        chk("reload start_coe", start_coe, 1);
        chk("reload bandlow", bandlow, 1000);
        chk("reload bandhi", bandhi, 4000);
        chk("reload select", filter_select, 2);
        chk("reload sample_cnt", sample_cnt, 102);
        coe_done = 1'b1;
        tick();
        coe_done = 1'b0;
        chk("reload stream sample_cnt", sample_cnt, 0);
        chk("reload stream start_coe", start_coe, 0);

        // Async reset mid-LOAD with nonzero state everywhere.
        src_valid = 1'b1; src_data = 32'hABCD;
        tick();
        src_valid = 1'b0;
        set_cfg(1'b1, 16'd2000, 16'd3000, 2'b00);
        tick();
        set_cfg(1'b0, 16'd0, 16'd0, 2'b00);
        repeat (67) tick();
        chk("pre-reset start_coe", start_coe, 1);
        chk("pre-reset data_put", data_put, 32'hABCD);
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("async reset");
        tick();
        reset = 1'b0;
        tick();

        // Load timeout with coe_done never asserted.
        set_cfg(1'b1, 16'd100, 16'd200, 2'b00);
        tick();
        set_cfg(1'b0, 16'd0, 16'd0, 2'b00);
        cnt = 0;
        while (busy && cnt < 5000) begin
            cnt++;
            tick();
        end
        chk("timeout load cycles", cnt, 4096);
        chk("timeout cfg_err", cfg_err, 1);
        chk("timeout start_coe", start_coe, 0);
        chk("timeout cfg_ready", cfg_ready, 1);
        tick();
        chk("timeout cfg_err pulse", cfg_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fir_stream_ctrl.md
Name: fir_stream_ctrl

Overview:
- Single-clock controller in front of the FIR/FIFO datapath.
- Accepts filter-configuration requests (band edges, filter type) from the communication interface and validates them.
- Sequences coefficient generation via start_coe, then meters source samples into the FIFO put port under full back-pressure.
- On reconfiguration during streaming: gates input, flushes the filter pipeline, then reloads coefficients.

Parameters:
- FS_HALF, 22050, maximum legal band edge (Nyquist, Hz).
- FLUSH_CYCLES, 64, cycles input is held off before reload (≥ filter tap count).
- LOAD_TIMEOUT, 4096, maximum cycles to wait for coe_done.
- DW, 32, sample width.

Ports:
- CLK  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  configuration accepted this cycle when cfg_valid=1.
- cfg_bandlow  in  16  requested low edge (Hz).
- cfg_bandhi  in  16  requested high edge (Hz).
- cfg_select  in  2  requested filter type: 00 bandpass, 01 lowpass, 10 highpass, 11 illegal.
- cfg_err  out  1  one-cycle pulse: rejected config or load timeout.
- coe_done  in  1  coefficient generator finished (level or pulse).
- start_coe  out  1  coefficient generation request.
- bandlow  out  16  applied low edge.
- bandhi  out  16  applied high edge.
- filter_select  out  2  applied filter type.
- src_valid  in  1  sample available.
- src_data  in  DW  sample.
- src_ready  out  1  sample accepted this cycle when src_valid=1.
- full  in  1  FIFO full, put side.
- data_put  out  DW  sample to FIFO.
- req_put  out  1  FIFO write strobe.
- busy  out  1  high in LOAD or FLUSH.
- sample_cnt  out  32  samples pushed since last completed LOAD.

Behaviour:
- Reset values (asynchronous, effective immediately, including mid-LOAD or mid-FLUSH):
  - state=IDLE.
  - All outputs 0: start_coe, req_put, data_put, bandlow, bandhi, filter_select, cfg_err, busy, sample_cnt.
  - Pending registers cleared.
- States: IDLE, LOAD, STREAM, FLUSH.
- cfg_ready is combinational: 1 in IDLE and STREAM, 0 in LOAD and FLUSH.
- A handshake occurs when cfg_valid & cfg_ready.
- Validity rule: bandlow < bandhi, bandhi ≤ FS_HALF, select ≠ 11.
  - Lowpass ignores bandlow.
  - Highpass ignores bandhi in the ordering check but still range-checks it.
- Invalid config: handshake completes, cfg_err=1 for the next cycle, state unchanged, applied outputs unchanged.
- Valid config in IDLE:
  - Next cycle: state=LOAD; bandlow/bandhi/filter_select take the new values; start_coe=1.
- Valid config in STREAM:
  - Values latched into pending registers; state=FLUSH; flush counter loaded with FLUSH_CYCLES.
- FLUSH:
  - src_ready=0, req_put=0; counter decrements each cycle.
  - When the counter reaches 0: pending values are applied to the outputs, state=LOAD, start_coe=1.
- LOAD:
  - start_coe held high; timeout counter increments from 0.
  - coe_done=1 → next cycle start_coe=0, state=STREAM, sample_cnt=0.
  - Counter reaching LOAD_TIMEOUT-1 without coe_done → start_coe=0, cfg_err pulse, state=IDLE.
  - If coe_done arrives on the timeout cycle, coe_done wins.
- STREAM:
  - src_ready = ~full & ~(cfg_valid & config valid).
  - A valid config has priority over a same-cycle sample; an invalid config does not block samples.
  - On a sample handshake: next cycle data_put=src_data, req_put=1, sample_cnt+1.
  - req_put is a single-cycle strobe per sample; latency 1 cycle; back-to-back samples give a continuous req_put.
  - data_put holds its last value when req_put=0.
- sample_cnt wraps at 2^32.
- full is sampled combinationally only; no skid buffer is required. A sample is accepted only when full=0 in the same cycle.
- busy = (state==LOAD) | (state==FLUSH).
- start_coe is never asserted outside LOAD.

Test Plan:
- Reset, then cfg 500/7000/00; coe_done asserted 10 cycles later → start_coe high for exactly 11 cycles, bandlow=500, bandhi=7000, state STREAM, sample_cnt=0.
- STREAM, src_valid continuous for 100 samples (incrementing data), full=0 → 100 req_put strobes, each one cycle after its handshake, data in order, sample_cnt=100.
- Assert full for 5 cycles mid-stream → src_ready=0 and no req_put for those cycles; no sample lost or duplicated.
- Cfg 7000/500/00, then cfg 0/30000/01 → cfg_err pulse each, outputs stay 500/7000/00, streaming uninterrupted.
- Valid cfg 1000/4000/10 during STREAM with simultaneous src_valid → sample rejected; 64 cycles with req_put=0; then start_coe rises and new values appear.
- LOAD with coe_done never asserted → cfg_err at cycle 4096, state IDLE. Separate run: reset asserted mid-LOAD → start_coe falls asynchronously and all outputs read 0.
